// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and helpers for the program-ROM arbiter.
//   port_id_t          : 1-bit requester id carried by the tag stage
//   PORT_FETCH/DATA    : ids of the instruction-fetch and data-load ports
//   starve_cnt_width() : counter width able to hold 0..STARVE_LIMIT
// Build option: ROM_ARB_RR_EN (selects round-robin arbitration, see
// rom_arb_select).
// -----------------------------------------------------------------------------
package rom_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_DATA  = 1'b1;

    // Width needed to count from 0 up to and including limit (minimum 1 bit).
    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) <= 64'(limit)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rom_arb_select.sv
// -----------------------------------------------------------------------------
// rom_arb_select
// Per-cycle grant logic for the two ROM requesters plus its fairness state.
// Build option ROM_ARB_RR_EN:
//   defined   : round-robin, the port not granted most recently wins contention
//   undefined : fixed priority to port 0 with a starvation counter for port 1
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req0_i, req1_i    : level requests from fetch / data port
//   gnt0_o, gnt1_o    : combinational one-hot (or zero) grants, low in reset
// -----------------------------------------------------------------------------
module rom_arb_select
    import rom_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef ROM_ARB_RR_EN

    // Id of the most recently granted port; resets to DATA so FETCH wins first.
    port_id_t last_q;
    port_id_t last_d;
    logic     win1;

    // Grant decision and pointer update
    always_comb begin
        last_d = last_q;
        win1   = req1_i & (~req0_i | (last_q == PORT_FETCH));
        gnt1_o = ~reset & win1;
        gnt0_o = ~reset & req0_i & ~win1;
        if (gnt0_o) begin
            last_d = PORT_FETCH;
        end else if (gnt1_o) begin
            last_d = PORT_DATA;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

`else

    localparam int unsigned    CNT_W = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             force1;
    logic             win1;

    // Grant decision and starvation counter update
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        force1       = (starve_cnt_q == LIMIT);
        win1         = req1_i & (~req0_i | force1);
        gnt1_o       = ~reset & win1;
        gnt0_o       = ~reset & req0_i & ~win1;
        if (!req1_i || gnt1_o) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            // Saturate so a long stall never wraps past the force point
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`endif

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares one synchronous-read program ROM between instruction fetch (port 0)
// and data/constant load (port 1). One access is granted per cycle, tagged
// with its owner, and the returned word is delivered to that port two cycles
// after the grant with a one-cycle rvalid pulse.
// Build option: ROM_ARB_RR_EN (round-robin instead of fixed priority).
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   req0_i/addr0_i           : fetch request and address (held until granted)
//   gnt0_o                   : fetch grant, combinational
//   rvalid0_o/rdata0_o       : fetch response pulse and held read data
//   req1_i/addr1_i/gnt1_o/rvalid1_o/rdata1_o : same for the data port
//   rom_addr_o               : address to the ROM, combinational
//   rom_data_i               : ROM word, valid the cycle after its address
// -----------------------------------------------------------------------------
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE    = 16,
    parameter int unsigned WORD_SIZE    = 20,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_i,
    input  logic [ADDR_SIZE-1:0] addr0_i,
    output logic                 gnt0_o,
    output logic                 rvalid0_o,
    output logic [WORD_SIZE-1:0] rdata0_o,
    input  logic                 req1_i,
    input  logic [ADDR_SIZE-1:0] addr1_i,
    output logic                 gnt1_o,
    output logic                 rvalid1_o,
    output logic [WORD_SIZE-1:0] rdata1_o,
    output logic [ADDR_SIZE-1:0] rom_addr_o,
    input  logic [WORD_SIZE-1:0] rom_data_i
);

    logic gnt0;
    logic gnt1;

    // Tag stage: marks that rom_data_i carries a word this cycle and for whom
    logic     tag_v_q;
    logic     tag_v_d;
    port_id_t tag_port_q;
    port_id_t tag_port_d;

    // Return stage: registered outputs
    logic                 rvalid0_q;
    logic                 rvalid0_d;
    logic                 rvalid1_q;
    logic                 rvalid1_d;
    logic [WORD_SIZE-1:0] rdata0_q;
    logic [WORD_SIZE-1:0] rdata0_d;
    logic [WORD_SIZE-1:0] rdata1_q;
    logic [WORD_SIZE-1:0] rdata1_d;

    rom_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk    (clk),
        .reset  (reset),
        .req0_i (req0_i),
        .req1_i (req1_i),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

    // ROM address mux; port 0 address is a harmless default when idle
    always_comb begin
        rom_addr_o = addr0_i;
        if (reset) begin
            rom_addr_o = '0;
        end else if (gnt1) begin
            rom_addr_o = addr1_i;
        end
    end

    // Next-state for the tag and return stages
    always_comb begin
        tag_v_d    = gnt0 | gnt1;
        tag_port_d = gnt1 ? PORT_DATA : PORT_FETCH;
        rvalid0_d  = tag_v_q & (tag_port_q == PORT_FETCH);
        rvalid1_d  = tag_v_q & (tag_port_q == PORT_DATA);
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        if (rvalid0_d) begin
            rdata0_d = rom_data_i;
        end
        if (rvalid1_d) begin
            rdata1_d = rom_data_i;
        end
    end

    // Pipeline registers; reset drops any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v_q    <= 1'b0;
            tag_port_q <= PORT_FETCH;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            tag_v_q    <= tag_v_d;
            tag_port_q <= tag_port_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
// Directed bench for rom_arbiter (STARVE_LIMIT = 2). Stimulus checks grants
// and the ROM address each cycle and queues the expected response; a separate
// negedge monitor pops and checks every rvalid pulse (port, data, cycle).
// Expected grant sequences depend on ROM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0;
    logic [15:0] addr0;
    logic        gnt0;
    logic        rvalid0;
    logic [19:0] rdata0;
    logic        req1;
    logic [15:0] addr1;
    logic        gnt1;
    logic        rvalid1;
    logic [19:0] rdata1;
    logic [15:0] rom_addr;
    logic [19:0] rom_data;

    typedef struct {
        logic        port;
        logic [19:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    rom_arbiter #(
        .ADDR_SIZE    (16),
        .WORD_SIZE    (20),
        .STARVE_LIMIT (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_i     (req0),
        .addr0_i    (addr0),
        .gnt0_o     (gnt0),
        .rvalid0_o  (rvalid0),
        .rdata0_o   (rdata0),
        .req1_i     (req1),
        .addr1_i    (addr1),
        .gnt1_o     (gnt1),
        .rvalid1_o  (rvalid1),
        .rdata1_o   (rdata1),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: word 5 is 0xABCDE, every other word is {4'h5, addr}
    function automatic logic [19:0] rom_val(input logic [15:0] a);
        return (a == 16'h0005) ? 20'hABCDE : {4'h5, a};
    endfunction

    // Synchronous-read ROM model
    always @(posedge clk) rom_data <= rom_val(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus starting just after a posedge; exp_g: -1 none, 0/1 port
    task automatic drive_cycle(input logic r0, input logic [15:0] a0,
                               input logic r1, input logic [15:0] a1, input int exp_g);
        logic [15:0] ea;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        #2;
        chk("gnt0", 32'(gnt0), 32'(exp_g == 0));
        chk("gnt1", 32'(gnt1), 32'(exp_g == 1));
        if (exp_g >= 0) begin
            ea = (exp_g == 1) ? a1 : a0;
            chk("rom_addr", 32'(rom_addr), 32'(ea));
            exp_q.push_back('{port: (exp_g == 1), data: rom_val(ea), cyc: cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, -1);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!reset && (rvalid0 || rvalid1)) begin
            chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid0=%b rvalid1=%b expected no response",
                         rvalid0, rvalid1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_port", 32'(rvalid1), 32'(mon_e.port));
                chk("resp_data", 32'(rvalid1 ? rdata1 : rdata0), 32'(mon_e.data));
                chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    int          g_cont[6];
    int          g_starve[5];
    logic [15:0] na0;
    logic [15:0] na1;

    initial begin
`ifdef ROM_ARB_RR_EN
        g_cont   = '{0, 1, 0, 1, 0, 1};
        g_starve = '{0, 0, 1, 0, 1};
`else
        g_cont   = '{0, 0, 1, 0, 0, 1};
        g_starve = '{0, 0, 0, 0, 1};
`endif
        reset = 1'b1;
        req0  = 1'b1;
        addr0 = 16'h0005;
        req1  = 1'b1;
        addr1 = 16'h0003;
        #3;
        // Reset state: everything low even with requests pending
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_gnt1", 32'(gnt1), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("rst_rvalid0", 32'(rvalid0), 32'(0));
        chk("rst_rvalid1", 32'(rvalid1), 32'(0));
        chk("rst_rdata0", 32'(rdata0), 32'(0));
        chk("rst_rdata1", 32'(rdata1), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Both ports requesting continuously; addresses advance only on grant
        na0 = 16'h0010;
        na1 = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, na0, 1'b1, na1, g_cont[i]);
            if (g_cont[i] == 0) na0 = na0 + 16'd1;
            else                na1 = na1 + 16'd1;
        end
        idle(2);

        // Single fetch from address 5
        drive_cycle(1'b1, 16'h0005, 1'b0, 16'h0, 0);
        idle(3);

        // Back-to-back data reads 1,2,3 then hold check
        for (int i = 1; i <= 3; i++) drive_cycle(1'b0, 16'h0, 1'b1, 16'(i), 1);
        idle(3);
        chk("rdata1_hold", 32'(rdata1), 32'(20'h50003));
        chk("rdata0_hold", 32'(rdata0), 32'(20'hABCDE));

        // Port 1 drops its request once; the starvation count must restart
        na0 = 16'h0030;
        na1 = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, na0, (i != 1), na1, g_starve[i]);
            if (g_starve[i] == 0) na0 = na0 + 16'd1;
            else                  na1 = na1 + 16'd1;
        end
        idle(3);

        // Reset the cycle after a grant: the access must never respond
        drive_cycle(1'b1, 16'h0007, 1'b0, 16'h0, 0);
        req0  = 1'b1;
        addr0 = 16'h0009;
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_gnt0", 32'(gnt0), 32'(0));
        chk("arst_rom_addr", 32'(rom_addr), 32'(0));
        chk("arst_rvalid0", 32'(rvalid0), 32'(0));
        chk("arst_rdata0", 32'(rdata0), 32'(0));
        chk("arst_rdata1", 32'(rdata1), 32'(0));
        @(posedge clk);
        #1;
        chk("arst_rvalid0_held", 32'(rvalid0), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_cycle(1'b1, 16'h0009, 1'b0, 16'h0, 0);
        idle(4);

        chk("drain_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single synchronous-read program ROM between two requesters: instruction fetch (port 0) and data/constant load (port 1). Each cycle the block picks at most one requester and drives its address to the ROM. It tags the access and routes the returned word to the owning port with a one-cycle valid pulse. It sits between the core's fetch/load units and the ROM instance, and the ROM must not be driven by anything else.

## Interface
- ADDR_SIZE, 16, ROM address width.
- WORD_SIZE, 20, ROM word width.
- STARVE_LIMIT, 4, consecutive denied cycles before port 1 is forced to win (fixed-priority build only; must be ≥1).

Ports:
- clk  in  1  sole clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0_i  in  1  port 0 (fetch) request, level.
- addr0_i  in  ADDR_SIZE  port 0 address, valid with req0_i.
- gnt0_o  out  1  port 0 request accepted this cycle (combinational).
- rvalid0_o  out  1  one-cycle pulse: rdata0_o holds a new word.
- rdata0_o  out  WORD_SIZE  port 0 read data, held until next port 0 response.
- req1_i, addr1_i, gnt1_o, rvalid1_o, rdata1_o  same as above, for port 1 (data).
- rom_addr_o  out  ADDR_SIZE  to ROM addr_i (combinational).
- rom_data_i  in  WORD_SIZE  from ROM value_o, valid one cycle after the address is presented.

## Operation
- Arbitration is per cycle and combinational. gnt0_o and gnt1_o are never both high. A grant is issued whenever at least one request is high.
- Fixed priority (default): port 0 wins contention. starve_cnt increments on each cycle with req1_i & ~gnt1_o. When starve_cnt == STARVE_LIMIT, port 1 wins that cycle. starve_cnt clears on gnt1_o or when req1_i is low. starve_cnt saturates at STARVE_LIMIT.
- rom_addr_o selects the address of the granted port. With no grant it selects addr0_i (don't-care to the ROM).
- Stage 1 (tag): on a grant, tag_v_q <= 1 and tag_port_q <= granted port; otherwise tag_v_q <= 0.
- Stage 2 (return): if tag_v_q, then rdata[tag_port_q]_o <= rom_data_i and rvalid[tag_port_q]_o <= 1. The other port's rvalid is 0, and its rdata is unchanged.
- Requesters must hold req/addr until granted. Dropping a request before grant is legal and has no side effects.
- Reset (asserted at any time) clears tag_v_q, tag_port_q, starve_cnt, both rvalid and both rdata, and the round-robin pointer. In-flight accesses are dropped with no response. gnt0_o, gnt1_o and rom_addr_o are forced to 0 while reset is high.

## Timing
- Cycle N: request and grant; the ROM latches rom_addr_o at the end of N.
- Cycle N+1: rom_data_i valid; tag stage valid.
- Cycle N+2: rvalidX_o high for one cycle; rdataX_o valid from N+2 until the next response to that port.
- Latency is 2 cycles from grant. Throughput is 1 access per cycle, back-to-back and interleaved across ports with no bubbles.
- Reset values: all outputs 0.

## Configuration
- ROM_ARB_RR_EN defined: round-robin arbitration replaces fixed priority. On contention the port not granted most recently wins. The pointer resets so port 0 wins the first contention. An uncontested grant also updates the pointer. starve_cnt is not built, and STARVE_LIMIT is ignored.
- ROM_ARB_RR_EN undefined: fixed priority plus the starvation counter, as described under Operation.

## Structure
- Package rom_arb_pkg contains:
  - port-id typedef (1 bit);
  - constants PORT_FETCH = 0 and PORT_DATA = 1;
  - starve counter width derived from STARVE_LIMIT.
- Sub-module rom_arb_select: grant logic, starve_cnt/RR pointer state, and the ROM_ARB_RR_EN split. The top level holds the address mux, the tag and return pipeline, and the output registers.

## Test plan
- req0 only, addr0=0x0005, ROM[5]=0xABCDE -> gnt0 same cycle, rvalid0 pulse 2 cycles later with rdata0=0xABCDE; rvalid1 stays 0.
- Both requests held continuously, fixed priority, STARVE_LIMIT=2 -> grants 0,0,1,0,0,1…; each returned word is routed to its own port at +2.
- Same stimulus with ROM_ARB_RR_EN -> grants alternate 0,1,0,1 starting with port 0.
- Back-to-back port 1 reads of addresses 1,2,3 -> rvalid1 high for 3 consecutive cycles carrying ROM[1..3]; rdata1 holds ROM[3] afterward.
- Reset asserted asynchronously the cycle after a grant -> no rvalid from that access; all outputs 0 immediately; the first post-reset access returns correctly at +2.
- req1 dropped after 1 denied cycle, then re-raised -> starve_cnt restarts from 0, so port 1 waits a full STARVE_LIMIT cycles again.
